sync_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that sits directly upstream of `dual_port_ram` and drives its `wclken`, `waddr` and `raddr` inputs. Together the two blocks form a synchronous first-word-fall-through FIFO. The controller owns the write pointer, the read pointer and the occupancy count, and produces full/empty/almost flags and sticky error flags. Data never passes through this block: `wdata` goes straight to the RAM, and the RAM's combinational `rdata` always presents the head word.

---
 rtl/sync_fifo_ctrl.sv | 100 ++++++++++
 tb/tb_sync_fifo_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer/occupancy controller for a single-clock FWFT FIFO
// built around dual_port_ram. Data never passes through this block; it only
// steers the RAM write enable and both addresses, and reports level and error flags.
module sync_fifo_ctrl #(
   parameter int unsigned DATADEPTH  = 45,
   parameter int unsigned AFULL_LVL  = 40,
   parameter int unsigned AEMPTY_LVL = 4,
   localparam int unsigned AW = $clog2(DATADEPTH),
   localparam int unsigned CW = $clog2(DATADEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic          rd_en,
   input  logic          err_clr,
   output logic          wclken,
   output logic [AW-1:0] waddr,
   output logic [AW-1:0] raddr,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          ovf_err,
   output logic          udf_err
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DATADEPTH - 1);
   localparam logic [CW-1:0] DEPTH_CNT = CW'(DATADEPTH);
   localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);
   localparam logic [CW-1:0] AEMPT_CNT = CW'(AEMPTY_LVL);

   logic wr_acc;
   logic rd_acc;

   // Level flags decoded purely from the registered occupancy.
   always_comb begin
      full         = (count == DEPTH_CNT);
      empty        = (count == '0);
      almost_full  = (count >= AFULL_CNT);
      almost_empty = (count <= AEMPT_CNT);
   end

   // Accept terms; full is the pre-pop value, so a write is refused when full
   // even if a read is popping in the same cycle.
   always_comb begin
      wr_acc = wr_en & ~full & ~rst;
      rd_acc = rd_en & ~empty;
      wclken = wr_acc;
   end

   // Write pointer, wrapping explicitly at the last RAM entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         waddr <= '0;
      end else if (wr_acc) begin
         waddr <= (waddr == LAST_ADDR) ? '0 : waddr + AW'(1);
      end
   end

   // Read pointer, wrapping explicitly at the last RAM entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raddr <= '0;
      end else if (rd_acc) begin
         raddr <= (raddr == LAST_ADDR) ? '0 : raddr + AW'(1);
      end
   end

   // Occupancy: net change of accepted writes minus accepted reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         case ({wr_acc, rd_acc})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky error flags; a new error in the same cycle as err_clr wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_err <= 1'b0;
         udf_err <= 1'b0;
      end else begin
         if (wr_en && full)
            ovf_err <= 1'b1;
         else if (err_clr)
            ovf_err <= 1'b0;
         if (rd_en && empty)
            udf_err <= 1'b1;
         else if (err_clr)
            udf_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: a behavioural RAM, a queue-based FIFO reference
// model, and a scoreboard monitor sampling on the falling edge.
module tb_sync_fifo_ctrl;

   localparam int DEPTH = 45;
   localparam int AFL   = 40;
   localparam int AEL   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] wdata = '0;
   logic       wclken;
   logic [5:0] waddr;
   logic [5:0] raddr;
   logic [5:0] count;
   logic       full, empty, almost_full, almost_empty, ovf_err, udf_err;

   sync_fifo_ctrl #(
      .DATADEPTH (DEPTH),
      .AFULL_LVL (AFL),
      .AEMPTY_LVL(AEL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .err_clr     (err_clr),
      .wclken      (wclken),
      .waddr       (waddr),
      .raddr       (raddr),
      .count       (count),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .ovf_err     (ovf_err),
      .udf_err     (udf_err)
   );

   always #5 clk = ~clk;

   // Behavioural stand-in for dual_port_ram: sync write, combinational read.
   logic [7:0] ram [0:63];
   always @(posedge clk) if (wclken) ram[waddr] <= wdata;

   typedef struct {
      int count;
      int waddr;
      int raddr;
      bit full, empty, af, ae, ovf, udf;
      bit wclken;
      bit chk_data;
      int data;
   } exp_t;

   exp_t sbq[$];

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int mq[$];
   int wtot = 0;
   int rtot = 0;
   bit m_ovf = 0;
   bit m_udf = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of stimulus and queue the response expected for it.
   task automatic step(input bit r, input bit w, input bit rd, input bit clr);
      exp_t e;
      int   sz;
      @(posedge clk);
      #1;
      rst     = r;
      wr_en   = w;
      rd_en   = rd;
      err_clr = clr;
      wdata   = 8'($urandom);
      if (r) begin
         mq.delete();
         wtot  = 0;
         rtot  = 0;
         m_ovf = 0;
         m_udf = 0;
      end
      sz         = mq.size();
      e.count    = sz;
      e.waddr    = wtot % DEPTH;
      e.raddr    = rtot % DEPTH;
      e.full     = (sz == DEPTH);
      e.empty    = (sz == 0);
      e.af       = (sz >= AFL);
      e.ae       = (sz <= AEL);
      e.ovf      = m_ovf;
      e.udf      = m_udf;
      e.wclken   = !r && w && (sz < DEPTH);
      e.chk_data = !r && rd && (sz > 0);
      e.data     = (sz > 0) ? mq[0] : 0;
      sbq.push_back(e);
      if (!r) begin
         if (w && sz == DEPTH) m_ovf = 1;
         else if (clr)         m_ovf = 0;
         if (rd && sz == 0)    m_udf = 1;
         else if (clr)         m_udf = 0;
         if (rd && sz > 0) begin
            void'(mq.pop_front());
            rtot++;
         end
         if (w && sz < DEPTH) begin
            mq.push_back(int'(wdata));
            wtot++;
         end
      end
   endtask

   // Monitor: compare DUT state against the queued expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("count",        int'(count),        e.count);
            chk("waddr",        int'(waddr),        e.waddr);
            chk("raddr",        int'(raddr),        e.raddr);
            chk("full",         int'(full),         int'(e.full));
            chk("empty",        int'(empty),        int'(e.empty));
            chk("almost_full",  int'(almost_full),  int'(e.af));
            chk("almost_empty", int'(almost_empty), int'(e.ae));
            chk("ovf_err",      int'(ovf_err),      int'(e.ovf));
            chk("udf_err",      int'(udf_err),      int'(e.udf));
            chk("wclken",       int'(wclken),       int'(e.wclken));
            if (e.chk_data && raddr < 6'd45)
               chk("rdata", int'(ram[raddr]), e.data);
            else if (e.chk_data)
               chk("raddr_range", int'(raddr), DEPTH - 1);
         end
      end
   end

   initial begin
      int wp;
      int rp;
      // Reset held with a write request present
      for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      // Fill completely, then one overflowing write
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      // Drain completely, then one underflowing read
      for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      // Simultaneous access at full and at empty
      for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
      step(0, 1, 1, 0);
      for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, 0);
      step(0, 1, 1, 0);
      step(0, 0, 0, 1);
      // Mid-level streaming at occupancy 20
      for (int i = 0; i < 19; i++) step(0, 1, 0, 0);
      for (int i = 0; i < 100; i++) step(0, 1, 1, 0);
      // err_clr colliding with a fresh overflow, then err_clr alone
      for (int i = 0; i < 25; i++) step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      // Randomised traffic with shifting bias and occasional reset
      wp = 50;
      rp = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) begin
            wp = $urandom_range(90, 10);
            rp = $urandom_range(90, 10);
         end
         step($urandom_range(499) == 0,
              $urandom_range(99) < wp,
              $urandom_range(99) < rp,
              $urandom_range(19) == 0);
      end
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
